rs_gpio_bank: RTL
=================

// Module: rs_gpio_bank
// PURPOSE
//  Parametrised multi-channel GPIO bank; sits between the I_BUF/O_BUFT pad wrappers and fabric logic.
//  Input path per channel: synchroniser, glitch filter, edge detection, sticky event flags.
//  Output path per channel: registered data and output-enable driving O_BUFT I/T.
//  Successor to the single-bit pass-through pad wrappers.
// PARAMETERS
//  WIDTH          8   number of channels (1..32)
//  SYNC_STAGES    2   input synchroniser flops (2..4)
//  FILTER_CYCLES  4   cycles an input must hold stable before DIN updates (0 = filter bypassed)
//  RESET_DOUT     0   WIDTH-bit reset value of PAD_O
//  RESET_OE       0   WIDTH-bit reset value of PAD_OE (0 = all channels high-Z)
// PORTS
//  CLK      in   1      bank clock, rising edge
//  RST_N    in   1      asynchronous, active-low reset
//  PAD_I    in   WIDTH  from I_BUF O (asynchronous to CLK)
//  PAD_O    out  WIDTH  to O_BUFT I
//  PAD_OE   out  WIDTH  to O_BUFT T; 1 = drive pad, 0 = high-Z
//  WR_STB   in   1      load DOUT and OE this cycle
//  DOUT     in   WIDTH  output data
//  OE       in   WIDTH  output enable
//  DIN      out  WIDTH  synchronised, filtered pad value
//  RISE     out  WIDTH  sticky rising-edge flags
//  FALL     out  WIDTH  sticky falling-edge flags
//  CLR      in   WIDTH  write-1-to-clear for RISE and FALL of the same bit
//  IRQ_MASK in   WIDTH  per-channel interrupt enable (GPIO_IRQ_EN builds only)
//  IRQ      out  1      level interrupt (GPIO_IRQ_EN builds only)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - PAD_O=RESET_DOUT, PAD_OE=RESET_OE.
//   - DIN, RISE, FALL, IRQ, sync chain, filter counters, QUAL all 0.
//  Output path:
//   - WR_STB=1 at edge N: PAD_O and PAD_OE take DOUT/OE at edge N; visible in cycle N+1.
//   - Both are updated in the same edge, so data is never driven stale when OE rises.
//   - WR_STB=0: PAD_O and PAD_OE hold.
//  Input sync: PAD_I passes through a SYNC_STAGES flop chain, giving S.
//  Filter, per channel:
//   - CNT = clog2(FILTER_CYCLES+1) bits.
//   - S==DIN: CNT<=0.
//   - S!=DIN and CNT==FILTER_CYCLES-1: DIN<=S, CNT<=0, QUAL<=1.
//   - Otherwise CNT<=CNT+1. CNT never wraps.
//   - A pulse shorter than FILTER_CYCLES synchronised cycles never reaches DIN.
//   - FILTER_CYCLES=0: DIN<=S every cycle; QUAL set on the first cycle after reset.
//   - Latency from a stable PAD_I change to DIN: SYNC_STAGES+FILTER_CYCLES cycles (+1 sampling uncertainty).
//  Qualification:
//   - Each channel's QUAL stays 0 until its first filtered update, or until SYNC_STAGES+FILTER_CYCLES cycles after reset.
//   - When that window expires, DIN is loaded with S with no edge recorded.
//   - Edges are suppressed while QUAL=0, so a pad held high through reset raises no RISE.
//  Edge flags (QUAL=1 only):
//   - DIN 0->1 sets RISE[i]; DIN 1->0 sets FALL[i]; same edge as the DIN update.
//   - A flag stays set until CLR[i]=1.
//   - Set and CLR[i] in the same cycle: set wins (the flag stays 1).
//  Channel direction:
//   - DIN tracks PAD_I regardless of PAD_OE, giving pad readback while driving.
//  Reset mid-operation:
//   - All state returns to reset values immediately; pending filter counts are discarded.
//   - After release the bank behaves exactly as after power-on.
// CONFIGURATION
//  Macro GPIO_IRQ_EN.
//  Defined:
//   - IRQ register <= |(IRQ_MASK & (RISE|FALL)).
//   - IRQ rises one cycle after the flag sets and falls one cycle after the last masked flag clears.
//  Undefined:
//   - IRQ_MASK is unused and no IRQ logic is built.
//   - The IRQ port is tied to 0.
// TESTING
//  1 Reset with PAD_I=8'hFF held, defaults:
//    -> DIN=8'hFF after 6 cycles; RISE=FALL=0; PAD_OE=0; PAD_O=0.
//  2 PAD_I[0] high pulse of 3 cycles, FILTER_CYCLES=4:
//    -> DIN[0] stays 0; RISE[0]=0.
//  3 PAD_I[3] 0->1 held:
//    -> DIN[3]=1 exactly 6-7 cycles later; RISE[3]=1 on that edge and held.
//    Then CLR=8'h08 -> RISE[3]=0 next cycle.
//  4 FALL[5] set and CLR[5]=1 on the same edge -> FALL[5]=1 afterwards.
//    Then a CLR alone clears it.
//  5 WR_STB=1 with DOUT=8'hA5, OE=8'h0F:
//    -> next cycle PAD_O=8'hA5 and PAD_OE=8'h0F simultaneously.
//    WR_STB=0 with DOUT changed -> outputs unchanged.
//  6 GPIO_IRQ_EN defined, IRQ_MASK=8'h04, rising edge on channel 2:
//    -> IRQ=1 one cycle after RISE[2].
//    Edge on channel 1 alone -> IRQ stays 0.
//    Assert RST_N=0 mid-filter count -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/rs_gpio_bank.sv
// Multi-channel GPIO bank: per-channel input synchroniser, glitch filter and sticky edge flags,
// plus a registered output path. Optional level interrupt is built when GPIO_IRQ_EN is defined.
module rs_gpio_bank #(
  parameter int              WIDTH         = 8,
  parameter int              SYNC_STAGES   = 2,
  parameter int              FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_DOUT   = '0,
  parameter logic [WIDTH-1:0] RESET_OE     = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] PAD_I,
  output logic [WIDTH-1:0] PAD_O,
  output logic [WIDTH-1:0] PAD_OE,
  input  logic             WR_STB,
  input  logic [WIDTH-1:0] DOUT,
  input  logic [WIDTH-1:0] OE,
  output logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  input  logic [WIDTH-1:0] CLR,
  input  logic [WIDTH-1:0] IRQ_MASK,
  output logic             IRQ
);

  localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam int WIN   = SYNC_STAGES + FILTER_CYCLES;
  localparam int WIN_W = $clog2(WIN + 1);

  logic [WIDTH-1:0] r_pad_o;
  logic [WIDTH-1:0] r_pad_oe;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_qual;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIN_W-1:0] r_win;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_rise_set;
  logic [WIDTH-1:0] w_fall_set;
  logic             w_win_fire;

  // Write port: WR_STB is a single-cycle strobe with no back-pressure; DOUT and OE
  // are captured together on the edge where WR_STB=1, so data is valid when OE rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pad_o  <= RESET_DOUT;
      r_pad_oe <= RESET_OE;
    end else if (WR_STB) begin
      r_pad_o  <= DOUT;
      r_pad_oe <= OE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= PAD_I;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_din;

  generate
    if (FILTER_CYCLES > 0) begin : g_filt
      logic [CNT_W-1:0] r_cnt [WIDTH];

      always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++)
          w_upd[i] = w_diff[i] && (r_cnt[i] == CNT_W'(FILTER_CYCLES - 1));
      end

      // Count restarts whenever the synchronised input agrees with DIN again.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (!w_diff[i] || w_upd[i]) r_cnt[i] <= '0;
            else                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end else begin : g_nofilt
      assign w_upd = w_diff;
    end
  endgenerate

  // Start-up window: unqualified channels adopt S silently when it expires.
  assign w_win_fire = (r_win == WIN_W'(WIN - 1));
  assign w_load     = w_upd | ({WIDTH{w_win_fire}} & ~r_qual);
  assign w_rise_set = r_qual & w_upd & w_s;
  assign w_fall_set = r_qual & w_upd & ~w_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_win  <= '0;
      r_din  <= '0;
      r_qual <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      if (r_win != WIN_W'(WIN)) r_win <= r_win + WIN_W'(1);
      r_din  <= (r_din & ~w_load) | (w_s & w_load);
      r_qual <= (FILTER_CYCLES == 0) ? '1 : (r_qual | w_load);
      r_rise <= (r_rise & ~CLR) | w_rise_set;
      r_fall <= (r_fall & ~CLR) | w_fall_set;
    end
  end

`ifdef GPIO_IRQ_EN
  logic r_irq;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_irq <= 1'b0;
    else        r_irq <= |(IRQ_MASK & (r_rise | r_fall));
  end

  assign IRQ = r_irq;
`else
  logic w_unused_irq_mask;

  assign w_unused_irq_mask = ^IRQ_MASK;
  assign IRQ               = 1'b0;
`endif

  assign PAD_O  = r_pad_o;
  assign PAD_OE = r_pad_oe;
  assign DIN    = r_din;
  assign RISE   = r_rise;
  assign FALL   = r_fall;

endmodule
